// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes engine: LANES inverse S-box lookups per cycle over a 128-bit state.
// Optional output register stage enabled by defining INV_SUB_BYTES_OREG_EN.
module inv_sub_bytes #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:127]  work_q, work_d;
  logic [6:0]    pos;
  logic          in_ready_q, busy_q, done_q;
  logic          done_release;

`ifdef INV_SUB_BYTES_OREG_EN
  logic         ovld_q;
  logic [0:127] odata_q;

  // DONE drains into the output register whenever it is empty or being emptied.
  assign done_release = !ovld_q || out_ready;
  assign out_valid    = ovld_q;
  assign out_state    = odata_q;
`else
  assign done_release = out_ready;
  assign out_valid    = done_q;
  assign out_state    = work_q;
`endif

  assign in_ready = in_ready_q;
  assign busy     = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    pos     = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Only the active group of LANES bytes is rewritten; the rest hold.
        for (int l = 0; l < LANES; l++) begin
          pos = 7'((int'(cnt_q) * LANES + l) * 8);
          work_d[pos +: 8] = inv_sbox(work_q[pos +: 8]);
        end
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (done_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they never depend on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef INV_SUB_BYTES_OREG_EN
      ovld_q     <= 1'b0;
      odata_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      in_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
`ifdef INV_SUB_BYTES_OREG_EN
      if (done_q && done_release) begin
        ovld_q  <= 1'b1;
        odata_q <= work_q;
      end else if (out_ready) begin
        ovld_q  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes: vector table, reset, backpressure, throughput and
// forward-S-box round trip.
module tb_inv_sub_bytes;

  localparam int LANES = 4;
  localparam int N     = 16 / LANES;
`ifdef INV_SUB_BYTES_OREG_EN
  localparam int LAT = N + 2;
  localparam bit OREG = 1'b1;
`else
  localparam int LAT = N + 1;
  localparam bit OREG = 1'b0;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:127] din;
    logic [0:127] dout;
  } vec_t;

  vec_t vecs [6];

  inv_sub_bytes #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for DUT", nm);
  endtask

  // Entered and left on a falling edge; returns result, accept-to-valid latency and input wait.
  task automatic xfer(input logic [0:127] din, output logic [0:127] dout,
                      output int lat, output int wait_in);
    dout    = '0;
    lat     = 0;
    wait_in = 0;
    while (!in_ready && wait_in < 100) begin
      @(negedge clk);
      wait_in++;
    end
    if (!in_ready) begin
      timeout_fail("xfer_in_ready");
      return;
    end
    in_valid = 1'b1;
    in_state = din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = ~din;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) begin
      timeout_fail("xfer_out_valid");
      return;
    end
    dout = out_state;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [0:127] res, hold, orig, din;
    int lat, w, cnt;
    int acc [3];
    bit seen;

    vecs[0].din = {16{8'h63}};                    vecs[0].dout = {16{8'h00}};
    vecs[1].din = {4{32'h0016ED63}};              vecs[1].dout = {4{32'h52FF5300}};
    vecs[2].din = {16{8'h7C}};                    vecs[2].dout = {16{8'h01}};
    vecs[3].din = {16{8'h00}};                    vecs[3].dout = {16{8'h52}};
    vecs[4].din = 128'h000102030405060708090A0B0C0D0E0F;
    vecs[4].dout = 128'h52096AD53036A538BF40A39E81F3D7FB;
    vecs[5].din = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    vecs[5].dout = 128'h172B047EBA77D626E169146355210C7D;

    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_state = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].din, res, lat, w);
      chk($sformatf("vec%0d_out", i), res, vecs[i].dout);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(LAT));
    end

    // Reset while the engine is mid-substitution.
    in_valid = 1'b1;
    in_state = {16{8'h63}};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("midrst_no_spurious", 128'(seen), 128'(0));

    // Backpressure: hold out_ready low for 20 cycles after out_valid.
    in_valid = 1'b1;
    in_state = vecs[1].din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 100);
    if (!out_valid) timeout_fail("bp_out_valid");
    hold = out_state;
    chk("bp_result", hold, vecs[1].dout);
    for (int i = 0; i < 20; i++) begin
      if (!OREG) begin
        in_valid = i[0];
        in_state = ~hold;
      end
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'(1));
      chk($sformatf("bp_stable_%0d", i), out_state, hold);
      if (!OREG) chk($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", 128'(in_ready), 128'(1));
    xfer(vecs[2].din, res, lat, w);
    chk("bp_next_wait", 128'(w), 128'(0));
    chk("bp_next_out", res, vecs[2].dout);

    // Throughput with out_ready held high and input always offered.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_state = vecs[3].din;
    cnt = 0;
    for (int k = 0; k < 10 * (N + 2) && cnt < 3; k++) begin
      if (out_valid) chk("tp_out", out_state, vecs[3].dout);
      if (in_ready) begin
        acc[cnt] = k;
        cnt++;
      end
      if (cnt == 3) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("tp_accepts", 128'(cnt), 128'(3));
    chk("tp_period_a", 128'(acc[1] - acc[0]), 128'(N + 2));
    chk("tp_period_b", 128'(acc[2] - acc[1]), 128'(N + 2));
    cnt = 0;
    while ((busy || out_valid) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (busy || out_valid) timeout_fail("tp_drain");
    out_ready = 1'b0;

    // Round trip: forward S-box model output fed through the inverse engine.
    for (int t = 0; t < 1000; t++) begin
      for (int b = 0; b < 16; b++) begin
        orig[b*8 +: 8] = 8'($urandom_range(0, 255));
        din[b*8 +: 8]  = SBOX[orig[b*8 +: 8]];
      end
      xfer(din, res, lat, w);
      chk($sformatf("rt_%0d", t), res, orig);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
